// File: rtl/acc_buffer_pkg.sv
// Shared types and constants for the multi-lane accumulation buffer.
package acc_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam logic MODE_OVERWRITE  = 1'b0;
   localparam logic MODE_ACCUMULATE = 1'b1;

endpackage

// File: rtl/acc_lane_alu.sv
// One lane of the write datapath: sign-extend, overwrite or accumulate,
// overflow detection and saturate/wrap of the result.
module acc_lane_alu
   import acc_buffer_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 32,
   parameter int SATURATE  = 1
) (
   input  logic                 mode,
   input  logic [ACC_WIDTH-1:0] old,
   input  logic [IN_WIDTH-1:0]  din,
   output logic [ACC_WIDTH-1:0] result,
   output logic                 ovf
);

   localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic [ACC_WIDTH-1:0] ext_s;
   logic [ACC_WIDTH:0]   sum_s;

   assign ext_s = ACC_WIDTH'($signed(din));
   assign sum_s = {old[ACC_WIDTH-1], old} + {ext_s[ACC_WIDTH-1], ext_s};

   // Select overwrite or accumulate; the extra sum bit disagreeing with the MSB marks overflow.
   always_comb begin
      result = ext_s;
      ovf    = 1'b0;
      if (mode == MODE_ACCUMULATE) begin
         ovf = sum_s[ACC_WIDTH] ^ sum_s[ACC_WIDTH-1];
         if (ovf && (SATURATE != 0)) begin
            result = sum_s[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
         end else begin
            result = sum_s[ACC_WIDTH-1:0];
         end
      end else begin
         result = ext_s;
         ovf    = 1'b0;
      end
   end

endmodule

// File: rtl/acc_buffer.sv
// Multi-lane accumulation buffer: two-stage read-modify-write pipeline with
// forwarding, 1-cycle reads, and a full-memory zero sweep after reset or clear.
module acc_buffer
   import acc_buffer_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int IN_WIDTH   = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int SATURATE   = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear_req,
   output logic                           busy,
   input  logic                           wr_req,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [NUM_LANES*IN_WIDTH-1:0]  wr_data,
   input  logic                           wr_mode,
   input  logic                           rd_req,
   input  logic [ADDR_WIDTH-1:0]          rd_addr,
   output logic [NUM_LANES*ACC_WIDTH-1:0] rd_data,
   output logic                           rd_valid,
   output logic [NUM_LANES-1:0]           ovf
);

   localparam int DATA_W = NUM_LANES * ACC_WIDTH;
   localparam int DEPTH  = 1 << ADDR_WIDTH;

   logic [DATA_W-1:0]             mem_r [DEPTH];
   state_t                        state_r, state_s;
   logic [ADDR_WIDTH-1:0]         cnt_r;
   logic                          s1_valid_r, s1_mode_r;
   logic [ADDR_WIDTH-1:0]         s1_addr_r;
   logic [NUM_LANES*IN_WIDTH-1:0] s1_data_r;
   logic [DATA_W-1:0]             s1_old_r;
   logic [DATA_W-1:0]             alu_res_s, wr_old_s, rd_word_s, rd_data_r;
   logic [NUM_LANES-1:0]          alu_ovf_s, ovf_r;
   logic                          rd_valid_r, idle_s, wr_acc_s, rd_acc_s;

   assign idle_s   = (state_r == IDLE);
   assign wr_acc_s = idle_s & wr_req & ~clear_req;
   assign rd_acc_s = idle_s & rd_req & ~clear_req;
   assign busy     = ~idle_s;
   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;
   assign ovf      = ovf_r;

   // The S1 entry commits at this edge, so anything reading its address now takes the ALU result.
   assign wr_old_s  = (s1_valid_r && (s1_addr_r == wr_addr)) ? alu_res_s : mem_r[wr_addr];
   assign rd_word_s = (s1_valid_r && (s1_addr_r == rd_addr)) ? alu_res_s : mem_r[rd_addr];

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      acc_lane_alu #(
         .IN_WIDTH  (IN_WIDTH),
         .ACC_WIDTH (ACC_WIDTH),
         .SATURATE  (SATURATE)
      ) u_alu (
         .mode   (s1_mode_r),
         .old    (s1_old_r[l*ACC_WIDTH +: ACC_WIDTH]),
         .din    (s1_data_r[l*IN_WIDTH +: IN_WIDTH]),
         .result (alu_res_s[l*ACC_WIDTH +: ACC_WIDTH]),
         .ovf    (alu_ovf_s[l])
      );
   end

   // Sweep control next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (clear_req) state_s = FLUSH;
            else           state_s = IDLE;
         end
         FLUSH: begin
            if (!s1_valid_r) state_s = CLEAR;
            else             state_s = FLUSH;
         end
         CLEAR: begin
            if (cnt_r == {ADDR_WIDTH{1'b1}}) state_s = IDLE;
            else                             state_s = CLEAR;
         end
         default: state_s = CLEAR;
      endcase
   end

   // State register and sweep address counter; reset restarts the sweep from address 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= CLEAR;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         if (state_r == CLEAR) cnt_r <= cnt_r + ADDR_WIDTH'(1);
         else                  cnt_r <= '0;
      end
   end

   // Write stage S1, read output register and sticky overflow flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_r <= 1'b0;
         s1_mode_r  <= MODE_OVERWRITE;
         s1_addr_r  <= '0;
         s1_data_r  <= '0;
         s1_old_r   <= '0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= '0;
         ovf_r      <= '0;
      end else begin
         s1_valid_r <= wr_acc_s;
         if (wr_acc_s) begin
            s1_mode_r <= wr_mode;
            s1_addr_r <= wr_addr;
            s1_data_r <= wr_data;
            s1_old_r  <= wr_old_s;
         end
         rd_valid_r <= rd_acc_s;
         if (rd_acc_s) rd_data_r <= rd_word_s;
         if ((state_r == FLUSH) && (state_s == CLEAR)) ovf_r <= '0;
         else if (s1_valid_r)                          ovf_r <= ovf_r | alu_ovf_s;
      end
   end

   // Single write port: the sweep has priority, otherwise S2 commits the S1 result.
   always_ff @(posedge clk) begin
      if (state_r == CLEAR)  mem_r[cnt_r]     <= '0;
      else if (s1_valid_r)   mem_r[s1_addr_r] <= alu_res_s;
   end

endmodule

// File: tb/tb_acc_buffer.sv
// Bench for acc_buffer: saturating and wrapping instances driven in parallel,
// table vectors plus hand sequences, reads checked through an expectation queue.
module tb_acc_buffer;

   localparam int NL = 2, IW = 8, AW = 12, ADW = 4;

   logic clk = 1'b0, reset = 1'b0, clear_req = 1'b0;
   logic wr_req = 1'b0, wr_mode = 1'b0, rd_req = 1'b0;
   logic [ADW-1:0] wr_addr = '0, rd_addr = '0;
   logic [NL*IW-1:0] wr_data = '0;
   logic busy_s, busy_w, rdv_s, rdv_w;
   logic [NL*AW-1:0] rdd_s, rdd_w;
   logic [NL-1:0] ovf_s, ovf_w;

   int checks = 0, errors = 0;
   int model [2][16][2];     // [0 = wrap, 1 = saturate][addr][lane]
   bit movf [2][2];
   logic [47:0] exp_q [$];   // {saturating word, wrapping word}

   typedef struct {
      bit wr; bit [3:0] wa; int d0; int d1; bit md;
      bit rd; bit [3:0] ra; logic [23:0] exp;
   } vec_t;
   vec_t vecs [12];

   always #5 clk = ~clk;

   acc_buffer #(.NUM_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy_s),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdd_s), .rd_valid(rdv_s), .ovf(ovf_s));

   acc_buffer #(.NUM_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy_w),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdd_w), .rd_valid(rdv_w), .ovf(ovf_w));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int acc_model(input int old, input int din, input bit md, input int sat, output bit o);
      int r;
      o = 1'b0;
      r = md ? old + din : din;
      if (r > 2047) begin
         o = 1'b1; r = (sat != 0) ? 2047 : r - 4096;
      end else if (r < -2048) begin
         o = 1'b1; r = (sat != 0) ? -2048 : r + 4096;
      end
      return r;
   endfunction

   function automatic logic [23:0] mword(input int s, input int a);
      return {12'(model[s][a][1]), 12'(model[s][a][0])};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit wr, input bit [3:0] wa, input int d0, input int d1, input bit md,
                        input bit rd, input bit [3:0] ra, input bit clr,
                        input logic [23:0] es, input logic [23:0] ew, input string tag);
      bit o;
      logic [47:0] e;
      wr_req = wr; wr_addr = wa; wr_data = {8'(d1), 8'(d0)}; wr_mode = md;
      rd_req = rd; rd_addr = ra; clear_req = clr;
      if (rd && !clr) exp_q.push_back({es, ew});
      if (wr && !clr) begin
         for (int s = 0; s < 2; s++)
            for (int l = 0; l < 2; l++) begin
               model[s][wa][l] = acc_model(model[s][wa][l], (l == 1) ? d1 : d0, md, s, o);
               if (o) movf[s][l] = 1'b1;
            end
      end
      if (clr) begin
         for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
               model[s][a][0] = 0; model[s][a][1] = 0;
            end
            movf[s][0] = 1'b0; movf[s][1] = 1'b0;
         end
      end
      tick;
      wr_req = 1'b0; rd_req = 1'b0; clear_req = 1'b0;
      check({tag, " rd_valid sat"}, 32'(rdv_s), 32'(rd && !clr));
      check({tag, " rd_valid wrap"}, 32'(rdv_w), 32'(rd && !clr));
      if (rdv_s) begin
         if (exp_q.size() == 0) begin
            check({tag, " unexpected read"}, 32'(rdv_s), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check({tag, " rd_data sat"}, 32'(rdd_s), 32'(e[47:24]));
            check({tag, " rd_data wrap"}, 32'(rdd_w), 32'(e[23:0]));
         end
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy_s && n < 100) begin
         n++;
         tick;
      end
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < 16; a++)
         cycle(1'b0, 4'd0, 0, 0, 1'b0, 1'b1, 4'(a), 1'b0, mword(1, a), mword(0, a), tag);
   endtask

   task automatic burst(input bit [3:0] a);
      for (int i = 0; i < 17; i++)
         cycle(1'b1, a, 127, 0, 1'b1, 1'b0, 4'd0, 1'b0, 24'd0, 24'd0, "burst");
      cycle(1'b0, 4'd0, 0, 0, 1'b0, 1'b1, a, 1'b0, mword(1, a), mword(0, a), "burst rd");
      check("burst ovf sat", 32'(ovf_s), 32'({movf[1][1], movf[1][0]}));
      check("burst ovf wrap", 32'(ovf_w), 32'({movf[0][1], movf[0][0]}));
   endtask

   initial begin
      int n;
      vecs[0]  = '{1'b1, 4'd3,  5,    0, 1'b1, 1'b1, 4'd3, 24'h000000};
      vecs[1]  = '{1'b1, 4'd3,  5,    0, 1'b1, 1'b1, 4'd3, 24'h000005};
      vecs[2]  = '{1'b1, 4'd3,  5,    0, 1'b1, 1'b0, 4'd0, 24'h000000};
      vecs[3]  = '{1'b1, 4'd3,  5,    0, 1'b1, 1'b1, 4'd3, 24'h00000F};
      vecs[4]  = '{1'b0, 4'd0,  0,    0, 1'b0, 1'b1, 4'd3, 24'h000014};
      vecs[5]  = '{1'b1, 4'd7, -1,    3, 1'b0, 1'b1, 4'd7, 24'h000000};
      vecs[6]  = '{1'b0, 4'd0,  0,    0, 1'b0, 1'b1, 4'd7, 24'h003FFF};
      vecs[7]  = '{1'b1, 4'd7, -128, -4, 1'b1, 1'b1, 4'd7, 24'h003FFF};
      vecs[8]  = '{1'b0, 4'd0,  0,    0, 1'b0, 1'b1, 4'd7, 24'hFFFF7F};
      vecs[9]  = '{1'b1, 4'd3,  127, -128, 1'b0, 1'b0, 4'd0, 24'h000000};
      vecs[10] = '{1'b0, 4'd0,  0,    0, 1'b0, 1'b1, 4'd3, 24'hF8007F};
      vecs[11] = '{1'b0, 4'd0,  0,    0, 1'b0, 1'b0, 4'd0, 24'h000000};
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++) begin
            model[s][a][0] = 0; model[s][a][1] = 0;
         end

      // Reset state, then the post-reset sweep length.
      tick; tick;
      check("reset busy", 32'(busy_s), 32'd1);
      check("reset rd_valid", 32'(rdv_s), 32'd0);
      check("reset rd_data", 32'(rdd_s), 32'd0);
      check("reset ovf", 32'(ovf_s), 32'd0);
      reset = 1'b1;
      count_busy(n);
      check("post-reset busy cycles", 32'(n), 32'd16);
      check("post-reset busy wrap", 32'(busy_w), 32'd0);
      read_all("init read");

      // Table vectors: accumulate with forwarding, overwrite, same-edge read.
      foreach (vecs[i])
         cycle(vecs[i].wr, vecs[i].wa, vecs[i].d0, vecs[i].d1, vecs[i].md,
               vecs[i].rd, vecs[i].ra, 1'b0, vecs[i].exp, vecs[i].exp, $sformatf("vec%0d", i));

      // Overflow: 17 x +127 saturates to 2047 or wraps to -1937.
      burst(4'd1);
      check("sat value", 32'(rdd_s[11:0]), 32'h7FF);
      check("wrap value", 32'(rdd_w[11:0]), 32'h86F);

      // Clear wins over a same-edge write; requests during the sweep are ignored.
      cycle(1'b1, 4'd5, 9, 0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0, 24'd0, "clear");
      n = 0;
      while (busy_s && n < 100) begin
         wr_req = 1'b1; rd_req = 1'b1; wr_addr = 4'd2; rd_addr = 4'd2;
         wr_data = 16'h0032; wr_mode = 1'b1; clear_req = (n == 3);
         n++;
         tick;
         check("busy rd_valid", 32'(rdv_s), 32'd0);
      end
      wr_req = 1'b0; rd_req = 1'b0; clear_req = 1'b0;
      check("clear busy cycles", 32'(n), 32'd17);
      check("clear ovf sat", 32'(ovf_s), 32'd0);
      check("clear ovf wrap", 32'(ovf_w), 32'd0);
      read_all("post-clear read");

      // Reset in the middle of a sweep at address 9.
      burst(4'd0);
      cycle(1'b0, 4'd0, 0, 0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0, 24'd0, "clear2");
      for (int i = 0; i < 10; i++) tick;
      check("held rd_data sat", 32'(rdd_s), 32'h0007FF);
      check("held rd_data wrap", 32'(rdd_w), 32'h00086F);
      reset = 1'b0;
      #1;
      check("midsweep reset busy", 32'(busy_s), 32'd1);
      check("midsweep reset rd_data", 32'(rdd_s), 32'd0);
      check("midsweep reset rd_data wrap", 32'(rdd_w), 32'd0);
      check("midsweep reset rd_valid", 32'(rdv_s), 32'd0);
      check("midsweep reset ovf", 32'(ovf_s), 32'd0);
      tick; tick;
      reset = 1'b1;
      count_busy(n);
      check("restart busy cycles", 32'(n), 32'd16);
      read_all("post-restart read");

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
